// File: rtl/breath_led_multi_if.sv
// Control and LED-drive bundle for breath_led_multi.
// The slave modport is the LED driver; the master is board-level control.
interface breath_led_multi_if #(
    parameter int unsigned CH_NUM = 4
);
    logic              enable;
    logic [1:0]        mode;
    logic [CH_NUM-1:0] led_out;
    logic              cycle_done;

    modport master (
        output enable,
        output mode,
        input  led_out,
        input  cycle_done
    );

    modport slave (
        input  enable,
        input  mode,
        output led_out,
        output cycle_done
    );
endinterface

// File: rtl/breath_led_multi.sv
// Multi-channel breathing-LED PWM driver: triangle-wave duty per channel,
// optional phase staggering between channels, and forced on/off modes.
module breath_led_multi #(
    parameter int unsigned CNT_TICK_MAX = 49,
    parameter int unsigned PWM_STEPS    = 1000,
    parameter int unsigned CH_NUM       = 4,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    breath_led_multi_if.slave  bus
);
    localparam int unsigned PHASE_STEP = (2 * PWM_STEPS) / CH_NUM;
    localparam int unsigned TICK_W     = (CNT_TICK_MAX > 0) ? $clog2(CNT_TICK_MAX + 1) : 1;
    localparam int unsigned PWM_W      = (PWM_STEPS > 1) ? $clog2(PWM_STEPS) : 1;
    localparam int unsigned PH_W       = $clog2(2 * PWM_STEPS);
    localparam int unsigned SUM_W      = PH_W + 1;

    localparam logic [TICK_W-1:0] TICK_MAX_C  = TICK_W'(CNT_TICK_MAX);
    localparam logic [PWM_W-1:0]  PWM_MAX_C   = PWM_W'(PWM_STEPS - 1);
    localparam logic [PH_W-1:0]   PHASE_MAX_C = PH_W'(2 * PWM_STEPS - 1);
    localparam logic [SUM_W-1:0]  PERIOD_C    = SUM_W'(2 * PWM_STEPS);
    localparam logic [SUM_W-1:0]  STEPS_C     = SUM_W'(PWM_STEPS);
    localparam logic [SUM_W-1:0]  PEAK_REF_C  = SUM_W'(2 * PWM_STEPS - 1);
    localparam logic [CH_NUM-1:0] DARK_C      = {CH_NUM{ACTIVE_LOW}};

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [1:0]        mode_q, mode_d;
    logic [CH_NUM-1:0] led_q, led_d;
    logic              done_q, done_d;

    logic              tick_end;
    logic              frame_end;
    logic              stagger;
    logic [CH_NUM-1:0] lit;

    assign tick_end  = (tick_q == TICK_MAX_C);
    assign frame_end = tick_end && (pwm_cnt_q == PWM_MAX_C);
    assign stagger   = (mode_q == 2'b01);

    // Per-channel phase offset, folded back into one breath period by a single
    // subtract: both operands are below the period, so the sum is below twice it.
    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        localparam logic [SUM_W-1:0] OFFSET_C = SUM_W'(k * PHASE_STEP);
        logic [SUM_W-1:0] p_raw;
        logic [SUM_W-1:0] p_mod;
        logic [SUM_W-1:0] duty;

        assign p_raw  = {1'b0, phase_q} + (stagger ? OFFSET_C : '0);
        assign p_mod  = (p_raw >= PERIOD_C) ? (p_raw - PERIOD_C) : p_raw;
        assign duty   = (p_mod < STEPS_C) ? p_mod : (PEAK_REF_C - p_mod);
        assign lit[k] = (SUM_W'(pwm_cnt_q) < duty);
    end

    always_comb begin
        tick_d    = '0;
        pwm_cnt_d = '0;
        phase_d   = '0;
        mode_d    = mode_q;
        led_d     = DARK_C;
        done_d    = 1'b0;
        if (bus.enable) begin
            tick_d    = tick_end ? '0 : tick_q + 1'b1;
            pwm_cnt_d = pwm_cnt_q;
            phase_d   = phase_q;
            if (tick_end) begin
                pwm_cnt_d = (pwm_cnt_q == PWM_MAX_C) ? '0 : pwm_cnt_q + 1'b1;
            end
            if (frame_end) begin
                phase_d = (phase_q == PHASE_MAX_C) ? '0 : phase_q + 1'b1;
                mode_d  = bus.mode;
            end
            done_d = frame_end && (phase_q == PHASE_MAX_C);
            unique case (mode_q)
                2'b10:   led_d = ~DARK_C;
                2'b11:   led_d = DARK_C;
                default: led_d = lit ^ DARK_C;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_q    <= '0;
            pwm_cnt_q <= '0;
            phase_q   <= '0;
            mode_q    <= 2'b00;
            led_q     <= DARK_C;
            done_q    <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            pwm_cnt_q <= pwm_cnt_d;
            phase_q   <= phase_d;
            mode_q    <= mode_d;
            led_q     <= led_d;
            done_q    <= done_d;
        end
    end

    assign bus.led_out    = led_q;
    assign bus.cycle_done = done_q;
endmodule

// File: tb/tb_breath_led_multi.sv
// Randomised self-checking bench for breath_led_multi against a behavioural
// model derived from the count of enabled clock edges since the last restart.
module tb_breath_led_multi;
    localparam int unsigned TICKS = 2;   // CNT_TICK_MAX + 1
    localparam int unsigned STEPS = 4;
    localparam int unsigned CH    = 2;
    localparam int unsigned FRAME = TICKS * STEPS;
    localparam int unsigned BREATH = FRAME * 2 * STEPS;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;

    breath_led_multi_if #(.CH_NUM(CH)) bus ();

    breath_led_multi #(
        .CNT_TICK_MAX(1),
        .PWM_STEPS   (STEPS),
        .CH_NUM      (CH),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Model state: enabled edges since restart, and the latched mode.
    int          m_n = 0;
    logic [1:0]  m_mode = 2'b00;
    logic [CH-1:0] exp_led = '1;
    logic        exp_done = 1'b0;

    function automatic logic [CH-1:0] model_led(input int n, input logic [1:0] m);
        int pwm, ph, p, d;
        logic [CH-1:0] r;
        pwm = (n / TICKS) % STEPS;
        ph  = (n / FRAME) % (2 * STEPS);
        r   = '1;
        if (m == 2'b10) return '0;
        if (m == 2'b11) return '1;
        for (int k = 0; k < CH; k++) begin
            p = (ph + ((m == 2'b01) ? k * ((2 * STEPS) / CH) : 0)) % (2 * STEPS);
            d = (p < STEPS) ? p : (2 * STEPS - 1 - p);
            r[k] = (pwm < d) ? 1'b0 : 1'b1;
        end
        return r;
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_n      <= 0;
            m_mode   <= 2'b00;
            exp_led  <= '1;
            exp_done <= 1'b0;
        end else if (bus.enable) begin
            exp_led  <= model_led(m_n, m_mode);
            exp_done <= ((m_n % BREATH) == BREATH - 1);
            if ((m_n % FRAME) == FRAME - 1) m_mode <= bus.mode;
            m_n <= m_n + 1;
        end else begin
            m_n      <= 0;
            exp_led  <= '1;
            exp_done <= 1'b0;
        end
    end

    always @(negedge sys_clk) begin
        if (cmp_en) begin
            checks++;
            if (bus.led_out !== exp_led || bus.cycle_done !== exp_done) begin
                errors++;
                $display("FAIL model t=%0t led_out=%b done=%b required led_out=%b done=%b",
                         $time, bus.led_out, bus.cycle_done, exp_led, exp_done);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    logic [CH-1:0] samp [BREATH];
    logic          dsamp [BREATH];

    task automatic grab_breath(input int mode_at, input logic [1:0] new_mode);
        for (int i = 0; i < BREATH; i++) begin
            @(negedge sys_clk);
            samp[i]  = bus.led_out;
            dsamp[i] = bus.cycle_done;
            if (i == mode_at) bus.mode = new_mode;
        end
    endtask

    task automatic check_frames(input string name, input int ch, input int duty[8]);
        int dark_lo;
        for (int f = 0; f < 8; f++) begin
            dark_lo = 0;
            for (int j = 0; j < FRAME; j++) if (samp[f * FRAME + j][ch] == 1'b0) dark_lo++;
            check($sformatf("%s_frame%0d", name, f), dark_lo, TICKS * duty[f]);
        end
    endtask

    task automatic check_done_once(input string name);
        int cnt;
        cnt = 0;
        for (int i = 0; i < BREATH; i++) if (dsamp[i]) cnt++;
        check({name, "_count"}, cnt, 1);
        check({name, "_last"}, 32'(dsamp[BREATH-1]), 1);
    endtask

    initial begin
        int rise [8] = '{0, 1, 2, 3, 3, 2, 1, 0};
        int fall [8] = '{3, 2, 1, 0, 0, 1, 2, 3};
        bus.enable = 1'b0;
        bus.mode   = 2'b00;
        #23 sys_rst_n = 1'b1;
        @(negedge sys_clk);
        cmp_en = 1'b1;

        // Disabled: dark and quiet.
        repeat (6) begin
            @(negedge sys_clk);
            check("idle_led", 32'(bus.led_out), 32'h3);
            check("idle_done", 32'(bus.cycle_done), 0);
        end

        // In-phase breath; request staggered before the final frame_end.
        bus.enable = 1'b1;
        grab_breath(60, 2'b01);
        check_frames("inphase_ch0", 0, rise);
        check_frames("inphase_ch1", 1, rise);
        check_done_once("inphase_done");

        grab_breath(-1, 2'b01);
        check_frames("stagger_ch0", 0, rise);
        check_frames("stagger_ch1", 1, fall);
        check_done_once("stagger_done");

        // Mid-frame switch to all-on takes effect only after frame_end.
        repeat (3) @(negedge sys_clk);
        bus.mode = 2'b10;
        @(negedge sys_clk);
        check("pre_on_led", 32'(bus.led_out), 32'h1);
        repeat (4) @(negedge sys_clk);
        @(negedge sys_clk);
        check("all_on_led", 32'(bus.led_out), 32'h0);
        repeat (3) @(negedge sys_clk);
        bus.mode = 2'b11;
        repeat (4) @(negedge sys_clk);
        check("pre_off_led", 32'(bus.led_out), 32'h0);
        @(negedge sys_clk);
        check("all_off_led", 32'(bus.led_out), 32'h3);

        // Back to in-phase, then drop enable at phase 5 of this breath.
        bus.mode = 2'b00;
        while (!((m_n % BREATH) >= 5 * FRAME + 2 && (m_n % BREATH) < 6 * FRAME)) @(negedge sys_clk);
        bus.enable = 1'b0;
        @(negedge sys_clk);
        check("drop_led", 32'(bus.led_out), 32'h3);
        check("drop_done", 32'(bus.cycle_done), 0);
        repeat (5) @(negedge sys_clk);
        bus.enable = 1'b1;
        grab_breath(-1, 2'b00);
        for (int i = 0; i < FRAME; i++) check($sformatf("restart_dark%0d", i), 32'(samp[i]), 32'h3);
        check_done_once("restart_done");

        // Asynchronous reset while forced on.
        bus.mode = 2'b10;
        repeat (2 * FRAME) @(negedge sys_clk);
        check("forced_on", 32'(bus.led_out), 32'h0);
        #2 sys_rst_n = 1'b0;
        #1 check("async_rst_led", 32'(bus.led_out), 32'h3);
        check("async_rst_done", 32'(bus.cycle_done), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge sys_clk);
            check($sformatf("post_rst_dark%0d", i), 32'(bus.led_out), 32'h3);
        end

        // Random enable/mode traffic, checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge sys_clk);
            if ($urandom_range(0, 199) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
        end
        if (!bus.enable) bus.enable = 1'b1;
        repeat (2 * BREATH) @(negedge sys_clk);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
